// File: rtl/dest_fifo_reader.sv
// dest_fifo_reader
// Consumer-side reader for destination FIFOs D0/D1. Issues round-robin pops
// from the empty flags, absorbs the one-cycle FIFO read latency, and hands
// words to a valid/ready sink through a 2-entry skid buffer so a stream can
// move one word per cycle.
//
// Build option: define DEST_FIFO_READER_CNT_EN to include the per-channel
// delivered-word counters (cnt_d0/cnt_d1, clear_cnt). When it is undefined
// the counters read as zero and clear_cnt is ignored.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_IDLE  | no pops; idle_rd high once nothing is pending or buffered
// ST_RUN   | pops issued whenever the buffer has room for the returning word
// ST_DRAIN | no new pops; in-flight and buffered words still go to the sink

module dest_fifo_reader #(
    parameter int DATA_SIZE = 6,
    parameter int CNT_SIZE  = 5
) (
    input  logic                 clk,
    input  logic                 reset_L,
    input  logic                 enable,
    input  logic                 empty_d0,
    input  logic                 empty_d1,
    input  logic [DATA_SIZE-1:0] data_d0,
    input  logic [DATA_SIZE-1:0] data_d1,
    input  logic                 out_ready,
    input  logic                 clear_cnt,
    output logic                 pop_d0,
    output logic                 pop_d1,
    output logic [DATA_SIZE-1:0] data_out,
    output logic                 chan_out,
    output logic                 valid_out,
    output logic                 idle_rd,
    output logic [CNT_SIZE-1:0]  cnt_d0,
    output logic [CNT_SIZE-1:0]  cnt_d1
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic                   pend_q, pend_d;
    logic                   pend_ch_q, pend_ch_d;
    logic [1:0]             occ_q, occ_d;
    logic                   last_q, last_d;
    logic [DATA_SIZE-1:0]   head_data_q, head_data_d;
    logic                   head_ch_q, head_ch_d;
    logic [DATA_SIZE-1:0]   skid_data_q, skid_data_d;
    logic                   skid_ch_q, skid_ch_d;

    logic                   dlv;
    logic                   cand0;
    logic                   cand1;
    logic                   grant1;
    logic [2:0]             fill;
    logic                   pop_ok;
    logic [1:0]             tail;
    logic [DATA_SIZE-1:0]   cap_data;

    assign valid_out = (occ_q != 2'd0);
    assign dlv       = valid_out & out_ready;
    assign data_out  = head_data_q;
    assign chan_out  = head_ch_q;

    // Arbitration and pop generation; fill is the occupancy the buffer will
    // hold after this edge, so a pop is only launched if its word will fit.
    always_comb begin
        cand0  = ~empty_d0;
        cand1  = ~empty_d1;
        grant1 = cand1 & (~cand0 | ~last_q);
        fill   = {1'b0, occ_q} + {2'b00, pend_q} - {2'b00, dlv};
        pop_ok = (state_q == ST_RUN) && (fill < 3'd2);
        pop_d0 = pop_ok & cand0 & ~grant1;
        pop_d1 = pop_ok & grant1;
    end

    // Read-tracking and arbitration history.
    always_comb begin
        pend_d    = pop_d0 | pop_d1;
        pend_ch_d = pop_d1;
        last_d    = last_q;
        if (pop_d0 | pop_d1) begin
            last_d = pop_d1;
        end
    end

    // Skid buffer: head advances on delivery, returning read data lands at
    // the tail slot computed after the head has moved.
    always_comb begin
        head_data_d = head_data_q;
        head_ch_d   = head_ch_q;
        skid_data_d = skid_data_q;
        skid_ch_d   = skid_ch_q;
        tail        = occ_q - {1'b0, dlv};
        cap_data    = pend_ch_q ? data_d1 : data_d0;
        occ_d       = occ_q + {1'b0, pend_q} - {1'b0, dlv};
        if (dlv) begin
            head_data_d = skid_data_q;
            head_ch_d   = skid_ch_q;
        end
        if (pend_q) begin
            if (tail == 2'd0) begin
                head_data_d = cap_data;
                head_ch_d   = pend_ch_q;
            end else begin
                skid_data_d = cap_data;
                skid_ch_d   = pend_ch_q;
            end
        end
    end

    // Next-state logic and idle indication.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (enable) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (!enable) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (enable) begin
                    state_d = ST_RUN;
                end else if ((occ_q == 2'd0) && !pend_q) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        idle_rd = (state_q == ST_IDLE) && (occ_q == 2'd0) && !pend_q;
    end

    // Control and datapath registers; an in-flight read is dropped on reset.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state_q     <= ST_IDLE;
            pend_q      <= 1'b0;
            pend_ch_q   <= 1'b0;
            occ_q       <= 2'd0;
            last_q      <= 1'b1;
            head_data_q <= '0;
            head_ch_q   <= 1'b0;
            skid_data_q <= '0;
            skid_ch_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            pend_q      <= pend_d;
            pend_ch_q   <= pend_ch_d;
            occ_q       <= occ_d;
            last_q      <= last_d;
            head_data_q <= head_data_d;
            head_ch_q   <= head_ch_d;
            skid_data_q <= skid_data_d;
            skid_ch_q   <= skid_ch_d;
        end
    end

`ifdef DEST_FIFO_READER_CNT_EN
    logic [CNT_SIZE-1:0] cnt_d0_q, cnt_d0_d;
    logic [CNT_SIZE-1:0] cnt_d1_q, cnt_d1_d;

    // Delivered-word counters; clear wins over a same-cycle delivery.
    always_comb begin
        cnt_d0_d = cnt_d0_q;
        cnt_d1_d = cnt_d1_q;
        if (clear_cnt) begin
            cnt_d0_d = '0;
            cnt_d1_d = '0;
        end else if (dlv) begin
            if (chan_out) begin
                cnt_d1_d = cnt_d1_q + 1'b1;
            end else begin
                cnt_d0_d = cnt_d0_q + 1'b1;
            end
        end
    end

    // Counter registers.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            cnt_d0_q <= '0;
            cnt_d1_q <= '0;
        end else begin
            cnt_d0_q <= cnt_d0_d;
            cnt_d1_q <= cnt_d1_d;
        end
    end

    assign cnt_d0 = cnt_d0_q;
    assign cnt_d1 = cnt_d1_q;
`else
    logic unused_clear_cnt;

    assign unused_clear_cnt = clear_cnt;
    assign cnt_d0           = '0;
    assign cnt_d1           = '0;
`endif

endmodule

// File: tb/tb_dest_fifo_reader.sv
// Bench for dest_fifo_reader: behavioural D0/D1 FIFOs with one-cycle read
// latency, per-channel expected-word queues filled as words are loaded, and
// a delivered-word counter model.
module tb_dest_fifo_reader;

    logic       clk = 1'b0;
    logic       reset_L;
    logic       enable;
    logic       empty_d0;
    logic       empty_d1;
    logic [5:0] data_d0;
    logic [5:0] data_d1;
    logic       out_ready;
    logic       clear_cnt;
    logic       pop_d0;
    logic       pop_d1;
    logic [5:0] data_out;
    logic       chan_out;
    logic       valid_out;
    logic       idle_rd;
    logic [4:0] cnt_d0;
    logic [4:0] cnt_d1;

    always #5 clk = ~clk;

    dest_fifo_reader #(.DATA_SIZE(6), .CNT_SIZE(5)) dut (
        .clk       (clk),
        .reset_L   (reset_L),
        .enable    (enable),
        .empty_d0  (empty_d0),
        .empty_d1  (empty_d1),
        .data_d0   (data_d0),
        .data_d1   (data_d1),
        .out_ready (out_ready),
        .clear_cnt (clear_cnt),
        .pop_d0    (pop_d0),
        .pop_d1    (pop_d1),
        .data_out  (data_out),
        .chan_out  (chan_out),
        .valid_out (valid_out),
        .idle_rd   (idle_rd),
        .cnt_d0    (cnt_d0),
        .cnt_d1    (cnt_d1)
    );

`ifdef DEST_FIFO_READER_CNT_EN
    localparam logic [4:0] CNT_THREE = 5'd3;
    localparam logic [4:0] CNT_WRAP1 = 5'd1;
`else
    localparam logic [4:0] CNT_THREE = 5'd0;
    localparam logic [4:0] CNT_WRAP1 = 5'd0;
`endif

    logic [5:0] q0[$];
    logic [5:0] q1[$];
    logic [5:0] exp0[$];
    logic [5:0] exp1[$];
    logic       chan_log[$];
    int         dlv_cyc[$];
    int         cyc;
    int         checks;
    int         errors;
    int         pops_seen;
    int         first_pop_cyc;
    int         first_vld_cyc;
    logic [4:0] m_cnt0;
    logic [4:0] m_cnt1;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic load(input bit ch, input logic [5:0] w);
        if (ch) begin
            q1.push_back(w);
            exp1.push_back(w);
        end else begin
            q0.push_back(w);
            exp0.push_back(w);
        end
        empty_d0 = (q0.size() == 0);
        empty_d1 = (q1.size() == 0);
    endtask

    task automatic clear_logs();
        chan_log.delete();
        dlv_cyc.delete();
        first_pop_cyc = -1;
        first_vld_cyc = -1;
    endtask

    // One clock: observe at the falling edge, then advance the FIFO models
    // just after the rising edge.
    task automatic step();
        logic p0;
        logic p1;
        logic dlv;
        @(negedge clk);
        p0  = pop_d0;
        p1  = pop_d1;
        dlv = valid_out & out_ready;
        check_val("pop_excl", {31'd0, p0 & p1}, 32'd0);
        check_val("pop0_empty", {31'd0, p0 & empty_d0}, 32'd0);
        check_val("pop1_empty", {31'd0, p1 & empty_d1}, 32'd0);
        check_val("cnt_d0", {27'd0, cnt_d0}, {27'd0, m_cnt0});
        check_val("cnt_d1", {27'd0, cnt_d1}, {27'd0, m_cnt1});
        if (p0 | p1) begin
            pops_seen++;
            if (first_pop_cyc < 0) first_pop_cyc = cyc;
        end
        if (valid_out && first_vld_cyc < 0) first_vld_cyc = cyc;
        if (dlv) begin
            if (chan_out) begin
                if (exp1.size() == 0) check_val("spurious_d1", 32'd1, 32'd0);
                else check_val("data_d1", {26'd0, data_out}, {26'd0, exp1.pop_front()});
            end else begin
                if (exp0.size() == 0) check_val("spurious_d0", 32'd1, 32'd0);
                else check_val("data_d0", {26'd0, data_out}, {26'd0, exp0.pop_front()});
            end
            chan_log.push_back(chan_out);
            dlv_cyc.push_back(cyc);
        end
`ifdef DEST_FIFO_READER_CNT_EN
        if (clear_cnt) begin
            m_cnt0 = 5'd0;
            m_cnt1 = 5'd0;
        end else if (dlv) begin
            if (chan_out) m_cnt1 = m_cnt1 + 5'd1;
            else m_cnt0 = m_cnt0 + 5'd1;
        end
`endif
        @(posedge clk);
        #1;
        cyc++;
        data_d0 = 6'($urandom_range(0, 63));
        data_d1 = 6'($urandom_range(0, 63));
        if (p0 && q0.size() > 0) data_d0 = q0.pop_front();
        if (p1 && q1.size() > 0) data_d1 = q1.pop_front();
        empty_d0 = (q0.size() == 0);
        empty_d1 = (q1.size() == 0);
    endtask

    task automatic run_until_done(input int max, input string tag);
        int n = 0;
        while ((exp0.size() + exp1.size()) != 0 && n < max) begin
            step();
            n++;
        end
        check_val({tag, "_done"}, exp0.size() + exp1.size(), 32'd0);
    endtask

    task automatic wait_idle(input int max, input string tag);
        int n = 0;
        while (!idle_rd && n < max) begin
            step();
            n++;
        end
        check_val({tag, "_idle"}, {31'd0, idle_rd}, 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_pop0"}, {31'd0, pop_d0}, 32'd0);
        check_val({tag, "_pop1"}, {31'd0, pop_d1}, 32'd0);
        check_val({tag, "_valid"}, {31'd0, valid_out}, 32'd0);
        check_val({tag, "_data"}, {26'd0, data_out}, 32'd0);
        check_val({tag, "_chan"}, {31'd0, chan_out}, 32'd0);
        check_val({tag, "_idle"}, {31'd0, idle_rd}, 32'd1);
        check_val({tag, "_cnt0"}, {27'd0, cnt_d0}, 32'd0);
        check_val({tag, "_cnt1"}, {27'd0, cnt_d1}, 32'd0);
    endtask

    initial begin
        int n;
        int p_before;
        int p_after;
        checks    = 0;
        errors    = 0;
        cyc       = 0;
        pops_seen = 0;
        m_cnt0    = 5'd0;
        m_cnt1    = 5'd0;
        reset_L   = 1'b0;
        enable    = 1'b0;
        out_ready = 1'b0;
        clear_cnt = 1'b0;
        empty_d0  = 1'b1;
        empty_d1  = 1'b1;
        data_d0   = 6'd0;
        data_d1   = 6'd0;
        clear_logs();
        #12;
        check_reset_outputs("rst");
        @(posedge clk);
        #1;
        reset_L = 1'b1;

        // Round-robin from reset: D0 wins first, then strict alternation.
        for (int i = 0; i < 3; i++) begin
            load(1'b0, 6'(6'h21 + i));
            load(1'b1, 6'(6'h31 + i));
        end
        out_ready = 1'b1;
        enable    = 1'b1;
        clear_logs();
        run_until_done(30, "rr");
        check_val("rr_len", chan_log.size(), 32'd6);
        for (int i = 0; i < 6 && i < chan_log.size(); i++)
            check_val("rr_chan", {31'd0, chan_log[i]}, i % 2);
        if (dlv_cyc.size() == 6) check_val("rr_thru", dlv_cyc[5] - dlv_cyc[0], 32'd5);
        check_val("rr_latency", first_vld_cyc - first_pop_cyc, 32'd2);
        enable = 1'b0;
        wait_idle(20, "rr");

        // Single-FIFO stream on D0 after a counter clear.
        clear_cnt = 1'b1;
        step();
        clear_cnt = 1'b0;
        load(1'b0, 6'h11);
        load(1'b0, 6'h12);
        load(1'b0, 6'h13);
        enable = 1'b1;
        clear_logs();
        run_until_done(20, "s");
        check_val("s_len", chan_log.size(), 32'd3);
        for (int i = 0; i < chan_log.size(); i++)
            check_val("s_chan", {31'd0, chan_log[i]}, 32'd0);
        if (dlv_cyc.size() == 3) check_val("s_thru", dlv_cyc[2] - dlv_cyc[0], 32'd2);
        check_val("s_cnt_d0", {27'd0, cnt_d0}, {27'd0, CNT_THREE});
        enable = 1'b0;
        wait_idle(20, "s");

        // Back-pressure mid-stream: buffer fills, pops stop, nothing lost.
        for (int i = 0; i < 4; i++) begin
            load(1'b0, 6'(6'h01 + i));
            load(1'b1, 6'(6'h05 + i));
        end
        enable = 1'b1;
        clear_logs();
        for (int i = 0; i < 3; i++) step();
        out_ready = 1'b0;
        step();
        step();
        p_before = pops_seen;
        for (int i = 0; i < 3; i++) step();
        check_val("bp_no_pop", pops_seen - p_before, 32'd0);
        check_val("bp_valid", {31'd0, valid_out}, 32'd1);
        out_ready = 1'b1;
        run_until_done(40, "bp");
        check_val("bp_len", chan_log.size(), 32'd8);
        enable = 1'b0;
        wait_idle(20, "bp");

        // Disable with a read in flight: it and buffered words still arrive.
        for (int i = 0; i < 4; i++) load(1'b0, 6'(6'h2A + i));
        enable = 1'b1;
        n = 0;
        p_before = pops_seen;
        while (pops_seen == p_before && n < 10) begin
            step();
            n++;
        end
        check_val("dis_first_pop", {31'd0, pops_seen != p_before}, 32'd1);
        step();
        enable = 1'b0;
        step();
        p_after = pops_seen;
        wait_idle(20, "dis");
        for (int i = 0; i < 3; i++) step();
        check_val("dis_no_pop_drain", pops_seen - p_after, 32'd0);
        check_val("dis_left", exp0.size(), q0.size());
        check_val("dis_idle_hold", {31'd0, idle_rd}, 32'd1);
        q0.delete();
        exp0.delete();
        empty_d0 = 1'b1;

        // Asynchronous reset with the skid buffer full.
        for (int i = 0; i < 4; i++) load(1'b0, 6'(6'h15 + i));
        out_ready = 1'b0;
        enable    = 1'b1;
        for (int i = 0; i < 5; i++) step();
        check_val("mr_valid", {31'd0, valid_out}, 32'd1);
        #2;
        reset_L = 1'b0;
        m_cnt0  = 5'd0;
        m_cnt1  = 5'd0;
        #1;
        check_reset_outputs("mr");
        q0.delete();
        q1.delete();
        exp0.delete();
        exp1.delete();
        empty_d0 = 1'b1;
        empty_d1 = 1'b1;
        @(posedge clk);
        #1;
        reset_L = 1'b1;
        for (int i = 0; i < 2; i++) begin
            load(1'b0, 6'(6'h3A + i));
            load(1'b1, 6'(6'h0A + i));
        end
        out_ready = 1'b1;
        clear_logs();
        run_until_done(30, "mr");
        if (chan_log.size() > 0) check_val("mr_first_d0", {31'd0, chan_log[0]}, 32'd0);
        check_val("mr_len", chan_log.size(), 32'd4);
        enable = 1'b0;
        wait_idle(20, "mr");

        // Counter wrap on D1, then clear coinciding with a delivery.
        clear_cnt = 1'b1;
        step();
        clear_cnt = 1'b0;
        for (int i = 0; i < 33; i++) load(1'b1, 6'(i));
        enable = 1'b1;
        run_until_done(80, "wrap");
        check_val("wrap_cnt_d1", {27'd0, cnt_d1}, {27'd0, CNT_WRAP1});
        out_ready = 1'b0;
        load(1'b1, 6'h2F);
        n = 0;
        while (!valid_out && n < 10) begin
            step();
            n++;
        end
        check_val("clr_valid", {31'd0, valid_out}, 32'd1);
        clear_cnt = 1'b1;
        out_ready = 1'b1;
        step();
        clear_cnt = 1'b0;
        check_val("clr_dlv_cnt_d1", {27'd0, cnt_d1}, 32'd0);
        check_val("clr_dlv_done", exp1.size(), 32'd0);
        enable = 1'b0;
        wait_idle(20, "end");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
